// File: rtl/sync_filter_pkg.sv
// Constants and helpers shared by the input-conditioning blocks.
// Pure declarations: no logic and no latency.
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEBOUNCE_MAX    = 65535;

  // Width of a counter that must hold 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_filter_if.sv
// Bundle of raw inputs and conditioned outputs for sync_filter.
// Level signals only: no handshake and no backpressure.
interface sync_filter_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (output data_in, input data_out, input rise, input fall);
  modport slave  (input data_in, output data_out, output rise, output fall);

endinterface

// File: rtl/sync_filter_chain.sv
// WIDTH-bit, STAGES-deep synchroniser chain with async reset to RESET_VALUE.
// Latency STAGES cycles; no logic sits between chain flops.
module sync_chain #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_q [STAGES];
  logic [WIDTH-1:0] chain_d [STAGES];

  always_comb begin
    chain_d[0] = d;
    for (int s = 1; s < STAGES; s++) begin
      chain_d[s] = chain_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        chain_q[s] <= RESET_VALUE;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        chain_q[s] <= chain_d[s];
      end
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/sync_filter.sv
// Multi-channel input conditioner: synchroniser, optional debounce, rise/fall pulses.
// Latency STAGES (+ DEBOUNCE_CYCLES when filtering); no backpressure.
module sync_filter
  import sync_pkg::*;
#(
  parameter int               WIDTH           = 1,
  parameter int               STAGES          = 2,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  sync_filter_if.slave  io
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_filter: STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 0 || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_debounce
    $error("sync_filter: DEBOUNCE_CYCLES must be in 0..65535");
  end

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  sync_chain #(
    .WIDTH       (WIDTH),
    .STAGES      (STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_chain (
    .clk   (clk),
    .reset (reset),
    .d     (io.data_in),
    .q     (sync_q)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic prev_q;
    logic prev_d;

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filt[i] = sync_q[i];
    end else begin : g_filter
      localparam int              CNT_W = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             out_q;
      logic             out_d;

      // Counter clears on agreement and at terminal count, so it never wraps.
      always_comb begin
        cnt_d = '0;
        out_d = out_q;
        if (sync_q[i] != out_q) begin
          if (cnt_q == TERM) begin
            out_d = sync_q[i];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q <= '0;
          out_q <= RESET_VALUE[i];
        end else begin
          cnt_q <= cnt_d;
          out_q <= out_d;
        end
      end

      assign filt[i] = out_q;
    end

    always_comb begin
      prev_d = filt[i];
    end

    // prev resets alongside data_out, so reset itself never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        prev_q <= RESET_VALUE[i];
      end else begin
        prev_q <= prev_d;
      end
    end

    assign rise_w[i] = filt[i] & ~prev_q;
    assign fall_w[i] = ~filt[i] & prev_q;
  end

  assign io.data_out = filt;
  assign io.rise     = rise_w;
  assign io.fall     = fall_w;

endmodule

// File: doc/sync_filter.md
# sync_filter

Parametrised multi-channel input conditioner: each of `WIDTH` asynchronous inputs passes through a `STAGES`-deep synchroniser, then an optional per-channel debounce filter. One-cycle rise/fall pulses are generated on the filtered value. It sits directly behind board-level inputs (buttons, external reset requests, flash status lines) and replaces the single-bit, fixed two-flop synchroniser everywhere a wider, filtered or edge-detected input is needed.

## Interface

- `WIDTH`, 1: number of independent channels.
- `STAGES`, 2: synchroniser flop count per channel, legal range 2–4.
- `DEBOUNCE_CYCLES`, 0: consecutive stable cycles required before the filtered output changes. 0 bypasses the filter; legal range 0–65535.
- `RESET_VALUE`, `{WIDTH{1'b0}}`: value loaded into every synchroniser flop and into `data_out` on reset.
- `clk`, input, 1: single system clock.
- `reset`, input, 1: asynchronous, active-high reset. Upstream logic deasserts it synchronously to `clk`.
- `data_in`, input, `WIDTH`: asynchronous raw inputs.
- `data_out`, output, `WIDTH`: synchronised, filtered value.
- `rise`, output, `WIDTH`: one-cycle pulse when `data_out[i]` goes 0→1.
- `fall`, output, `WIDTH`: one-cycle pulse when `data_out[i]` goes 1→0.

## Operation

- Reset values: all synchroniser flops and `data_out` = `RESET_VALUE`; debounce counters = 0; edge-history register = `RESET_VALUE`; `rise` = `fall` = 0.
- Synchroniser: `sync_q[i]` is the last flop of a `STAGES`-deep chain clocked by `clk`. No logic is placed between chain flops.
- Bypass (`DEBOUNCE_CYCLES` = 0): `data_out` = `sync_q`.
- Filter, evaluated per channel on each edge:
  - If `sync_q[i]` == `data_out[i]`, the counter clears.
  - If they differ and the counter < `DEBOUNCE_CYCLES`−1, the counter increments.
  - If they differ and the counter == `DEBOUNCE_CYCLES`−1, `data_out[i]` <= `sync_q[i]` and the counter clears.
- A mismatch lasting fewer than `DEBOUNCE_CYCLES` cycles is discarded: the counter clears and `data_out` is unchanged.
- Edge detection:
  - `prev` register tracks `data_out` one cycle late.
  - `rise` = `data_out & ~prev`; `fall` = `~data_out & prev`.
  - Each pulse is high for exactly the first cycle of the new `data_out` value.
- Channels are fully independent. Simultaneous changes on several channels give simultaneous, independent pulses.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`, minimum 1. The counter never wraps because it clears at terminal count.

## Timing

- An input change, stable from before edge 1, reaches `sync_q` after edge `STAGES`.
- Bypass: `data_out` and the pulse change after edge `STAGES`.
- Filter: `data_out` changes after edge `STAGES` + `DEBOUNCE_CYCLES`, and the pulse is asserted in that same cycle.
- Reset asserted mid-count or mid-pulse:
  - All outputs go to their reset values immediately, without waiting for `clk`.
  - No pulse is generated on the reset transition or on the first cycle after release.
- After reset release, an input that differs from `RESET_VALUE` propagates with normal latency and produces a normal edge pulse.
- Illegal `STAGES` or `DEBOUNCE_CYCLES` values fail elaboration.

## Structure

- Shared package `sync_pkg`:
  - `SYNC_STAGES_MIN` = 2 and `SYNC_STAGES_MAX` = 4.
  - `DEBOUNCE_MAX` = 65535.
  - Function `cnt_width(n)` returning `$clog2(n+1)`, floored at 1.
- One sub-module, `sync_chain`: a `WIDTH`-bit, `STAGES`-deep flop chain with asynchronous reset to `RESET_VALUE`.
- The top level holds the per-channel filter counters, the `prev` register and the edge logic in a generate loop.

## Test plan

Test configuration is `WIDTH`=4, `STAGES`=2, `DEBOUNCE_CYCLES`=3, `RESET_VALUE`=4'b0000, 20 ns clock unless stated.

- Reset check: hold `reset`=1 with `data_in`=4'b1111 → `data_out`=0, `rise`=`fall`=0 throughout. Release `reset`, keep `data_in` steady → `data_out`=4'b1111 after edge 5, `rise`=4'b1111 for exactly one cycle.
- Glitch rejection: from `data_in`=0, drive `data_in[0]`=1 for 2 cycles, then 0 → `data_out[0]` stays 0 and `rise` never asserts.
- Debounce latency: set `data_in[2]`=1, hold it, then clear it → `data_out[2]` rises after edge 5, `rise[2]`=1 for one cycle. Clearing gives `fall[2]`=1 five cycles later.
- Independent channels: change `data_in[1]` and `data_in[3]` (0→1) on the same cycle and `data_in[0]` (0→1) one cycle later → `rise` shows 4'b1010, then 4'b0001 on the next cycle.
- Reset mid-operation: assert `reset` for 44 ns while `data_out`=4'b1111 and a counter is at 1 → outputs clear asynchronously, no `fall` pulse. After release, the value re-propagates with full 5-edge latency.
- Bypass: rebuild with `DEBOUNCE_CYCLES`=0, `STAGES`=3 → a 1-cycle input pulse, when captured, appears on `data_out` after edge 3, with `rise` and `fall` on consecutive cycles.
